// File: rtl/picorv_boot_sequencer.sv
// picorv_boot_sequencer
//   Boot controller for the picorv32 core complex. Holds the core in reset,
//   accepts a program image on a 32-bit valid/ready stream (header word with
//   the byte count in [23:0], then payload words) and writes it byte-serially,
//   little-endian, into instruction memory. Releases core reset after a
//   settle delay and re-arms for a new image when the core traps.
//
// Ports:
//   clk                 system clock
//   resetn              asynchronous active-low reset
//   din / val_in        image stream data and valid
//   ready_upward        sequencer can accept din (IDLE and WORD only)
//   instr_config_wr_en  byte write strobe to instruction memory
//   instr_config_addr   byte address of the current write
//   instr_config_din    byte data of the current write
//   core_resetn         active-low reset to the core
//   trap                core trap indication (only looked at in RUN)
//   busy                high in every state except RUN
//   load_err            sticky: last header was illegal
module picorv_boot_sequencer #(
  parameter int ADDR_BITS     = 24,
  parameter int MAX_BYTES     = 16384,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          din,
  input  logic                 val_in,
  output logic                 ready_upward,
  output logic                 instr_config_wr_en,
  output logic [ADDR_BITS-1:0] instr_config_addr,
  output logic [7:0]           instr_config_din,
  output logic                 core_resetn,
  input  logic                 trap,
  output logic                 busy,
  output logic                 load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WORD,
    S_EMIT,
    S_SETTLE,
    S_RUN
  } state_t;

  localparam int                CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [23:0]       MAX_N       = 24'(MAX_BYTES);

  // A legal image must fit the byte address counter without wrapping.
  if (64'(MAX_BYTES) > (64'd1 << ADDR_BITS)) begin : g_addr_check
    $error("MAX_BYTES does not fit in ADDR_BITS");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_check
    $error("SETTLE_CYCLES must be at least 1");
  end

  state_t                 state;
  logic [ADDR_BITS-1:0]   byte_addr;
  logic [23:0]            remaining;
  logic [1:0]             lane;
  logic [CNT_W-1:0]       settle_cnt;
  logic [31:0]            shreg;
  logic [23:0]            hdr_n;
  logic                   xfer;

  // ready is a pure state decode, forced low while reset is asserted.
  assign ready_upward = resetn && ((state == S_IDLE) || (state == S_WORD));
  assign xfer         = val_in && ready_upward;
  assign hdr_n        = din[23:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= S_IDLE;
      byte_addr          <= '0;
      remaining          <= '0;
      lane               <= '0;
      settle_cnt         <= '0;
      instr_config_wr_en <= 1'b0;
      instr_config_addr  <= '0;
      instr_config_din   <= '0;
      core_resetn        <= 1'b0;
      busy               <= 1'b1;
      load_err           <= 1'b0;
    end else begin
      instr_config_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if ((hdr_n == 24'd0) || (hdr_n > MAX_N)) begin
              load_err <= 1'b1;
            end else begin
              load_err  <= 1'b0;
              remaining <= hdr_n;
              byte_addr <= '0;
              state     <= S_WORD;
            end
          end
        end
        S_WORD: begin
          if (xfer) begin
            lane  <= 2'd0;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          instr_config_wr_en <= 1'b1;
          instr_config_addr  <= byte_addr;
          instr_config_din   <= shreg[7:0];
          byte_addr          <= byte_addr + ADDR_BITS'(1);
          remaining          <= remaining - 24'd1;
          lane               <= lane + 2'd1;
          // Image end takes priority over word end; leftover bytes of a
          // partial final word are simply dropped.
          if (remaining == 24'd1) begin
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else if (lane == 2'd3) begin
            state <= S_WORD;
          end
        end
        S_SETTLE: begin
          // Counting starts in the cycle of the last write, so the core
          // leaves reset SETTLE_CYCLES+1 cycles after that write.
          if (settle_cnt == SETTLE_LAST) begin
            core_resetn <= 1'b1;
            busy        <= 1'b0;
            state       <= S_RUN;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (trap) begin
            core_resetn <= 1'b0;
            busy        <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte shifter: data path only, no reset needed.
  always_ff @(posedge clk) begin
    if ((state == S_WORD) && xfer) begin
      shreg <= din;
    end else if (state == S_EMIT) begin
      shreg <= shreg >> 8;
    end
  end

endmodule

// File: tb/tb_picorv_boot_sequencer.sv
module tb_picorv_boot_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] din = '0;
  logic        val_in = 1'b0;
  logic        ready_upward;
  logic        instr_config_wr_en;
  logic [23:0] instr_config_addr;
  logic [7:0]  instr_config_din;
  logic        core_resetn;
  logic        trap = 1'b0;
  logic        busy;
  logic        load_err;

  picorv_boot_sequencer #(
    .ADDR_BITS(24),
    .MAX_BYTES(16384),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .din(din),
    .val_in(val_in),
    .ready_upward(ready_upward),
    .instr_config_wr_en(instr_config_wr_en),
    .instr_config_addr(instr_config_addr),
    .instr_config_din(instr_config_din),
    .core_resetn(core_resetn),
    .trap(trap),
    .busy(busy),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         sb[$];
  int          wr_times[$];
  logic [31:0] stim_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  logic        prev_ready = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [23:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Monitor: every write strobe is popped against the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (instr_config_wr_en) begin
        chk("ready_in_emit", {31'd0, prev_ready}, 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%02h want no write",
                   instr_config_addr, instr_config_din);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", {8'd0, instr_config_addr}, {8'd0, e.a});
          chk("wr_data", {24'd0, instr_config_din}, {24'd0, e.d});
        end
        wr_times.push_back(cyc);
        last_wr_cyc = cyc;
      end
      prev_ready = ready_upward;
    end else begin
      prev_ready = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic push(input logic [31:0] w, output int acc);
    int n = 0;
    din = w;
    val_in = 1'b1;
    while (!ready_upward && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_upward) begin
      total++;
      bad++;
      $display("FAIL push_timeout: ready_upward got 0 want 1");
    end
    acc = cyc + 1;
    @(negedge clk);
    val_in = 1'b0;
  endtask

  // Streams stim_q with val_in toggling every cycle.
  task automatic stream_toggle();
    int  idx = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    while (idx < stim_q.size() && guard < 300) begin
      din = stim_q[idx];
      val_in = ph;
      if (ph && ready_upward) idx++;
      ph = !ph;
      @(negedge clk);
      guard++;
    end
    val_in = 1'b0;
    if (guard >= 300) begin
      total++;
      bad++;
      $display("FAIL toggle_timeout: words sent %0d want %0d", idx, stim_q.size());
    end
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (core_resetn !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_run_reached"}, {31'd0, core_resetn}, 32'd1);
    chk({name, "_release_delay"}, cyc - last_wr_cyc, 32'd5);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_trap(input string name);
    trap = 1'b1;
    @(negedge clk);
    trap = 1'b0;
    chk({name, "_core_resetn"}, {31'd0, core_resetn}, 32'd0);
    chk({name, "_ready"}, {31'd0, ready_upward}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_wr_en"}, {31'd0, instr_config_wr_en}, 32'd0);
    chk({name, "_addr"}, {8'd0, instr_config_addr}, 32'd0);
    chk({name, "_din"}, {24'd0, instr_config_din}, 32'd0);
    chk({name, "_core_resetn"}, {31'd0, core_resetn}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    chk({name, "_ready"}, {31'd0, ready_upward}, 32'd0);
    chk({name, "_load_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    int acc;
    int dummy;
    int n;
    int exp_t[8] = '{2, 3, 4, 5, 7, 8, 9, 10};

    // Reset state
    #1 resetn = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, ready_upward}, 32'd1);

    // Test 1: N=8, two full words, timing of writes and release
    exp_wr(24'd0, 8'h11); exp_wr(24'd1, 8'h22); exp_wr(24'd2, 8'h33); exp_wr(24'd3, 8'h44);
    exp_wr(24'd4, 8'h55); exp_wr(24'd5, 8'h66); exp_wr(24'd6, 8'h77); exp_wr(24'd7, 8'h88);
    wr_times.delete();
    push(32'h0000_0008, acc);
    push(32'h4433_2211, dummy);
    push(32'h8877_6655, dummy);
    wait_run("t1");
    chk("t1_nwr", wr_times.size(), 32'd8);
    if (wr_times.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t1_wr_time", wr_times[i] - acc, exp_t[i]);
    end
    // Stream is back-pressured in RUN
    din = 32'h0000_0004;
    val_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run_backpressure", {31'd0, ready_upward}, 32'd0);
    end
    val_in = 1'b0;
    pulse_trap("t5_trap1");

    // Test 2: N=5, partial last word; trap held during load is ignored
    exp_wr(24'd0, 8'hAA); exp_wr(24'd1, 8'hBB); exp_wr(24'd2, 8'hCC); exp_wr(24'd3, 8'hDD);
    exp_wr(24'd4, 8'hEE);
    push(32'h0000_0005, dummy);
    trap = 1'b1;
    push(32'hDDCC_BBAA, dummy);
    push(32'h0000_00EE, dummy);
    trap = 1'b0;
    wait_run("t2");
    pulse_trap("t2_trap");

    // Test 3: illegal headers, then a legal one with junk in [31:24]
    push(32'h0000_0000, dummy);
    chk("t3_n0_err", {31'd0, load_err}, 32'd1);
    chk("t3_n0_ready", {31'd0, ready_upward}, 32'd1);
    push(32'h0000_4001, dummy);
    chk("t3_big_err", {31'd0, load_err}, 32'd1);
    chk("t3_big_ready", {31'd0, ready_upward}, 32'd1);
    exp_wr(24'd0, 8'hBE); exp_wr(24'd1, 8'hBA); exp_wr(24'd2, 8'hFE); exp_wr(24'd3, 8'hCA);
    push(32'hA500_0004, dummy);
    chk("t3_err_clear", {31'd0, load_err}, 32'd0);
    push(32'hCAFE_BABE, dummy);
    wait_run("t3");
    pulse_trap("t3_trap");

    // Test 4: val_in toggling every cycle during an N=8 load
    exp_wr(24'd0, 8'h11); exp_wr(24'd1, 8'h22); exp_wr(24'd2, 8'h33); exp_wr(24'd3, 8'h44);
    exp_wr(24'd4, 8'h55); exp_wr(24'd5, 8'h66); exp_wr(24'd6, 8'h77); exp_wr(24'd7, 8'h88);
    stim_q.delete();
    stim_q.push_back(32'h0000_0008);
    stim_q.push_back(32'h4433_2211);
    stim_q.push_back(32'h8877_6655);
    stream_toggle();
    wait_run("t4");
    pulse_trap("t4_trap");

    // Test 6: reset asserted after the third byte of a load
    exp_wr(24'd0, 8'h11); exp_wr(24'd1, 8'h22); exp_wr(24'd2, 8'h33);
    push(32'h0000_0008, dummy);
    push(32'h4433_2211, dummy);
    n = 0;
    while (!(instr_config_wr_en && instr_config_addr == 24'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_third_byte_seen", {8'd0, instr_config_addr}, 32'd2);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("t6_async");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("t6_sb_drained", sb.size(), 32'd0);
    @(negedge clk);
    chk("t6_idle_ready", {31'd0, ready_upward}, 32'd1);
    exp_wr(24'd0, 8'h01); exp_wr(24'd1, 8'h02); exp_wr(24'd2, 8'h03); exp_wr(24'd3, 8'h04);
    push(32'h0000_0004, dummy);
    push(32'h0403_0201, dummy);
    wait_run("t6");

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picorv_boot_sequencer.md
Name: picorv_boot_sequencer

Overview:
- Boot controller for the picorv32 core complex.
- Holds the core in reset, accepts a program image as a 32-bit valid/ready stream, and writes it byte-serially into instruction memory through the instr_config byte-write port.
- Releases core reset after a settle delay.
- Re-arms for a new image when the core traps.

Parameters:
ADDR_BITS, 24, width of instr_config_addr and of the byte address counter
MAX_BYTES, 16384, largest legal image size in bytes
SETTLE_CYCLES, 4, cycles core_resetn stays low after the last byte write (minimum 1)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
din  input  32  image stream data; header word first, then payload words
val_in  input  1  din valid
ready_upward  output  1  sequencer can accept din
instr_config_wr_en  output  1  byte write strobe to instruction memory
instr_config_addr  output  ADDR_BITS  byte address of current write
instr_config_din  output  8  byte data of current write
core_resetn  output  1  active-low reset to the core and its memory-mapped ports
trap  input  1  core trap indication
busy  output  1  high in every state except RUN
load_err  output  1  sticky: last header was illegal

Behaviour:
- Reset (async, resetn=0): state=IDLE; byte_addr=0; remaining=0; instr_config_wr_en=0, instr_config_addr=0, instr_config_din=0; core_resetn=0; load_err=0; busy=1; ready_upward=0 (gated by resetn).
- Handshake: a transfer occurs when val_in && ready_upward on a rising clk edge. ready_upward is a combinational decode: 1 in IDLE and WORD, else 0. din is ignored when no transfer occurs.
- IDLE:
  - Header transfer: N=din[23:0], din[31:24] ignored.
  - N==0 or N>MAX_BYTES: load_err<=1, stay in IDLE.
  - Otherwise: load_err<=0, remaining<=N, byte_addr<=0, go to WORD.
- WORD:
  - Transfer: latch din into a 32-bit shift register and set lane=0. Go to EMIT.
- EMIT (one byte per cycle; all instr_config outputs registered):
  - Each cycle: wr_en=1, addr=byte_addr, data=shreg[7:0].
  - Then shreg>>=8, byte_addr++, remaining--, lane++.
  - Byte order is little-endian: din[7:0] is written first.
  - remaining reaches 0: go to SETTLE. Unused upper bytes of the final word are discarded.
  - Else lane reaches 4: go to WORD.
  - wr_en=0 in every state other than EMIT.
- SETTLE: counts SETTLE_CYCLES cycles with core_resetn=0, then goes to RUN.
- RUN:
  - core_resetn=1, busy=0, ready_upward=0. Stream data is back-pressured and not consumed.
  - trap==1 sampled high: go to IDLE and drive core_resetn=0 from the next cycle.
- trap is ignored in all states except RUN.
- byte_addr width is ADDR_BITS and never wraps for a legal N (MAX_BYTES ≤ 2^ADDR_BITS, checked by assertion).
- Timing for a header accepted at edge t:
  - First payload word earliest at t+1.
  - Its bytes are written at t+2..t+5.
  - Steady-state cost is 5 cycles per full word.
  - core_resetn rises SETTLE_CYCLES+1 cycles after the last wr_en cycle.
- resetn asserted mid-load: immediate return to the reset state; the partially written image is left as is.
- Simultaneous events:
  - val_in held high across IDLE→WORD: the next word is treated as payload, not as a header.
  - trap in the same cycle as the RUN entry edge is not seen until the first RUN cycle.

Test Plan:
1. Header N=8, payload words 0x44332211 and 0x88776655 → writes (addr,data) 0:0x11, 1:0x22, 2:0x33, 3:0x44, 4:0x55, 5:0x66, 6:0x77, 7:0x88 on consecutive cycles (gap of one cycle between words). core_resetn rises 5 cycles after the write to addr 7; busy falls with it.
2. Header N=5, payload 0xDDCCBBAA and 0x000000EE → five writes, the last being addr 4 data 0xEE. Upper bytes of the second word produce no writes. State then goes to SETTLE.
3. Header N=0, then N=MAX_BYTES+1 → no writes, load_err=1, still IDLE with ready_upward=1. A following header N=4 clears load_err.
4. Back-pressure: val_in toggled 1/0 every cycle during the N=8 load → identical write sequence; ready_upward is 0 in every EMIT cycle; no word is lost or duplicated.
5. In RUN, pulse trap for 1 cycle → core_resetn=0 on the next cycle, ready_upward=1. Reloading N=4 with 0xCAFEBABE writes 0xBE,0xBA,0xFE,0xCA to addrs 0..3, then the core is released again.
6. Assert resetn=0 for 2 cycles after the 3rd byte of a load → outputs return to reset values asynchronously. After release the sequencer accepts a fresh header and writes from addr 0.
